// File: rtl/arbiter_encoder_pkg.sv
// Shared types and constants for the rotating-priority arbiter with binary grant index.
// Imported by the interface, the decoder and the arbiter top.
package arbiter_encoder_pkg;

    localparam int NUM_REQ          = 8;
    localparam int IDX_W            = 3;
    localparam int HOLD_W           = 4;
    localparam int MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    // Modulo-NUM_REQ successor; wraps 7 -> 0 through the 3-bit width.
    function automatic idx_t next_idx(input idx_t idx);
        return idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/arbiter_encoder_if.sv
// Request/grant bundle between requesters and the arbiter.
// The master side drives req; the slave side (arbiter) returns the grant.
interface arbiter_encoder_if;
    import arbiter_encoder_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               valid;
    logic               timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output valid,
        output timeout
    );

endinterface

// File: rtl/arbiter_encoder_decoder.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decoder
    import arbiter_encoder_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_encoder.sv
// Rotating-priority arbiter: grants one of NUM_REQ requesters for at most MAX_HOLD
// cycles, reports the owner as a binary index and pulses timeout on forced release.
module arbiter_encoder
    import arbiter_encoder_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset,
    arbiter_encoder_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    idx_t              ptr;
    idx_t              grant_idx_r;
    logic              valid_r;
    logic              timeout_r;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_found;
    idx_t              pick_idx;
    idx_t              cand;
    logic              owner_req;
    logic              release_now;

    // Rotating scan: first set request at or above ptr, wrapping through the 3-bit add.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + idx_t'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_req   = bus.req[grant_idx_r];
    assign release_now = !owner_req || (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_idx_r <= '0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_idx_r <= pick_idx;
                        valid_r     <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // A still-requesting owner at the hold limit is a forced release.
                        state       <= IDLE;
                        ptr         <= next_idx(grant_idx_r);
                        grant_idx_r <= '0;
                        valid_r     <= 1'b0;
                        hold_cnt    <= '0;
                        timeout_r   <= owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_idx = grant_idx_r;
    assign bus.valid     = valid_r;
    assign bus.timeout   = timeout_r;

    decoder u_decoder (
        .idx    (grant_idx_r),
        .en     (valid_r),
        .onehot (bus.grant)
    );

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        valid_r |-> (bus.grant == (NUM_REQ'(1) << grant_idx_r)));

    a_idle_outputs : assert property (@(posedge clk) disable iff (reset)
        !valid_r |-> (bus.grant == '0) && (grant_idx_r == '0));

endmodule

// File: tb/tb_arbiter_encoder.sv
// Scoreboard bench for arbiter_encoder: two instances (default and short hold limit)
// share one request stream and are checked against a behavioural model.
module tb_arbiter_encoder;

    localparam int LIM0 = 8;
    localparam int LIM1 = 2;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [7:0] req_drv;

    int checks = 0;
    int errors = 0;

    obs_t q0[$];
    obs_t q1[$];

    int m_busy[2];
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];

    arbiter_encoder_if bus0 ();
    arbiter_encoder_if bus1 ();

    assign bus0.req = req_drv;
    assign bus1.req = req_drv;

    arbiter_encoder #(.MAX_HOLD(LIM0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    arbiter_encoder #(.MAX_HOLD(LIM1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t observe0();
        obs_t o;
        o.grant   = bus0.grant;
        o.idx     = bus0.grant_idx;
        o.valid   = bus0.valid;
        o.timeout = bus0.timeout;
        return o;
    endfunction

    function automatic obs_t observe1();
        obs_t o;
        o.grant   = bus1.grant;
        o.idx     = bus1.grant_idx;
        o.valid   = bus1.valid;
        o.timeout = bus1.timeout;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                     name, $time, act.grant, act.idx, act.valid, act.timeout,
                     exp.grant, exp.idx, exp.valid, exp.timeout);
        end
    endtask

    // Model: a requester keeps the grant while requesting, for at most lim cycles;
    // the search for the next owner starts just after the previous owner.
    task automatic model_step(input int j, input int lim, input logic [7:0] r, output obs_t e);
        int c;
        logic to;
        to = 1'b0;
        if (m_busy[j] != 0) begin
            if (!r[m_owner[j]]) begin
                m_busy[j] = 0;
                m_ptr[j]  = (m_owner[j] + 1) % 8;
            end else if (m_held[j] >= lim) begin
                m_busy[j] = 0;
                m_ptr[j]  = (m_owner[j] + 1) % 8;
                to        = 1'b1;
            end else begin
                m_held[j] = m_held[j] + 1;
            end
        end else if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                c = (m_ptr[j] + k) % 8;
                if (r[c]) begin
                    m_busy[j]  = 1;
                    m_owner[j] = c;
                    m_held[j]  = 1;
                    break;
                end
            end
        end
        e.valid   = (m_busy[j] != 0);
        e.idx     = (m_busy[j] != 0) ? 3'(m_owner[j]) : 3'd0;
        e.grant   = (m_busy[j] != 0) ? (8'h01 << m_owner[j]) : 8'h00;
        e.timeout = to;
    endtask

    // Expected-response producer: one entry per instance per clock edge.
    initial begin
        obs_t e0;
        obs_t e1;
        for (int j = 0; j < 2; j++) begin
            m_busy[j] = 0; m_owner[j] = 0; m_held[j] = 0; m_ptr[j] = 0;
        end
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int j = 0; j < 2; j++) begin
                    m_busy[j] = 0; m_owner[j] = 0; m_held[j] = 0; m_ptr[j] = 0;
                end
                e0 = '0;
                e1 = '0;
            end else begin
                model_step(0, LIM0, req_drv, e0);
                model_step(1, LIM1, req_drv, e1);
            end
            q0.push_back(e0);
            q1.push_back(e1);
        end
    end

    // Monitor: samples late in each cycle and compares against the queued expectation.
    initial begin
        obs_t exp0;
        obs_t exp1;
        forever begin
            @(posedge clk);
            #6;
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow t=%0t: got q0=%0d q1=%0d entries, expected at least 1 each",
                         $time, q0.size(), q1.size());
            end else begin
                exp0 = q0.pop_front();
                exp1 = q1.pop_front();
                if (reset) begin
                    exp0 = '0;
                    exp1 = '0;
                end
                check_obs("dut0_hold8", observe0(), exp0);
                check_obs("dut1_hold2", observe1(), exp1);
            end
        end
    end

    task automatic drive(input logic [7:0] r, input int n);
        req_drv = r;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asserts reset between edges and checks the outputs drop before the next edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        check_obs("async_reset_dut0", observe0(), obs_t'(0));
        check_obs("async_reset_dut1", observe1(), obs_t'(0));
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int hold;
        int mode;
        logic [7:0] r;
        reset   = 1'b1;
        req_drv = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // All requesters active: round-robin with timeouts.
        drive(8'hFF, 80);
        drive(8'h00, 3);

        pulse_reset();
        drive(8'b0010_0100, 3);
        drive(8'b0010_0000, 4);
        drive(8'h00, 2);

        pulse_reset();
        drive(8'b1000_0000, 3);
        drive(8'h00, 1);
        drive(8'b1000_0001, 3);
        drive(8'h00, 2);

        pulse_reset();
        drive(8'b0000_1000, 2);
        for (int k = 0; k < 5; k++) begin
            drive((k % 2 == 0) ? 8'b0001_1010 : 8'b0000_1000, 1);
        end
        drive(8'b0001_0010, 3);
        drive(8'h00, 2);

        pulse_reset();
        drive(8'b0100_0000, 4);
        pulse_reset();
        drive(8'b0100_0001, 3);
        drive(8'h00, 2);

        pulse_reset();
        drive(8'b0000_0010, 8);
        drive(8'h00, 2);

        cyc = 0;
        r   = 8'h00;
        while (cyc < 800) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) r = 8'h00;
            else if (mode <= 3) r = 8'h01 << $urandom_range(0, 7);
            else if (mode <= 6) r = 8'($urandom);
            hold = $urandom_range(1, 12);
            drive(r, hold);
            cyc += hold;
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset();
                cyc++;
            end
        end

        drive(8'h00, 2);
        @(posedge clk);
        #8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_encoder.md
ARBITER_ENCODER -- requirements
Module: arbiter_encoder

Interface
- REQ-001: Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per requester (legal 2..15).
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-high; clears all state immediately.
- REQ-004: req  input  8  request lines, bit i = requester i, multi-hot allowed.
- REQ-005: grant  output  8  one-hot grant, all-zero when idle.
- REQ-006: grant_idx  output  3  binary index of granted requester, 0 when idle.
- REQ-007: valid  output  1  high while a grant is held.
- REQ-008: timeout  output  1  one-cycle pulse on forced release at MAX_HOLD.

Function
- REQ-009: Two states SHALL exist: IDLE, GRANT.
- REQ-010: In IDLE with req == 0, state, outputs and pointer SHALL hold.
- REQ-011: In IDLE with req != 0 at an edge, the block SHALL select the first set bit scanning upward from pointer ptr, wrapping 7->0, and enter GRANT.
- REQ-012: Grant latency SHALL be exactly one cycle: req sampled at edge N, grant/grant_idx/valid visible after edge N.
- REQ-013: grant SHALL always equal the one-hot decode of grant_idx while valid = 1.
- REQ-014: On entering GRANT, hold counter hold_cnt SHALL load 0; it increments each cycle spent in GRANT.
- REQ-015: In GRANT, if req[grant_idx] == 0 at an edge, the block SHALL return to IDLE, clear grant/valid/grant_idx, set ptr = grant_idx + 1 mod 8.
- REQ-016: In GRANT, if req[grant_idx] == 1 and hold_cnt == MAX_HOLD-1 at an edge, the block SHALL force release as in REQ-015 and assert timeout for the following cycle only.
- REQ-017: Changes on req bits other than grant_idx SHALL NOT affect a held grant.
- REQ-018: After any release, at least one IDLE cycle SHALL occur before the next grant (no back-to-back grants).
- REQ-019: ptr arithmetic SHALL be 3-bit modulo 8; grant_idx = 7 releases to ptr = 0.
- REQ-020: A requester whose req drops in the same edge it would be granted SHALL not be granted (sampled value rules).
- REQ-021: Outputs SHALL be registered; no combinational path from req to any output.

Reset
- REQ-022: Reset SHALL force state = IDLE, ptr = 0, hold_cnt = 0, grant = 0, grant_idx = 0, valid = 0, timeout = 0.
- REQ-023: Reset asserted during GRANT SHALL drop grant and valid without waiting for a clock edge.
- REQ-024: First edge after reset deassertion SHALL behave as IDLE with ptr = 0.

Structure
- REQ-025: Shared package SHALL hold NUM_REQ = 8, IDX_W = 3, state encoding (IDLE = 0, GRANT = 1), default MAX_HOLD.
- REQ-026: grant SHALL be produced by instantiating the existing 3-8 decoder module decoder on registered grant_idx, gated by valid.
- REQ-027: Selection logic (rotating priority scan) SHALL be a single combinational block inside arbiter_encoder; no further sub-modules.

Verification
- REQ-028: Reset, req = 8'b1111_1111 held -> grants in order idx 0,1,2..7,0, each ending with timeout after 8 cycles, one idle cycle between.
- REQ-029: req = 8'b0010_0100 from reset -> grant_idx = 2 after one cycle; drop req[2] -> IDLE, ptr = 3; next grant idx 5.
- REQ-030: Granted idx 7, req[7] dropped -> ptr = 0; req = 8'b1000_0001 -> grant idx 0.
- REQ-031: Grant idx 3 held, toggle req[4], req[1] every cycle -> grant stays 8'b0000_1000, valid = 1 until req[3] drops.
- REQ-032: Assert reset asynchronously mid-GRANT (idx 6) -> grant = 0, valid = 0 before next edge; after release req = 8'b0100_0001 -> grant idx 0.
- REQ-033: MAX_HOLD = 2, req = 8'b0000_0010 held -> valid high exactly 2 cycles, timeout pulse 1 cycle, re-grant idx 1 after one idle cycle.
